// File: rtl/dpi_pkg.sv
// Shared definitions for the dpi lane monitor.
//   LANE_DW / LANE_KW : data bits and K-bits carried by one lane.
//   rotl1             : 32-bit rotate left by one, the checksum step.
//   popcount          : number of set bits in a 32-bit word.
package dpi_pkg;

  localparam int LANE_DW = 32;
  localparam int LANE_KW = 4;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/dpi_chan.sv
// One direction of the dpi lane monitor.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears every output
//   dat/datk/datv : lane data, per-byte K flags and per-lane valid
//   cnt        : lane-words captured so far, saturates at WIDTH
//   kcnt       : K-bits seen in captured lanes, wraps mod 2^32
//   sum        : running checksum, rotl1(sum) ^ XOR(valid lane data)
//   full       : cnt == WIDTH
//   ovf        : sticky, a valid cycle was dropped for lack of room
// A cycle is captured whole or not at all: if the valid lanes do not all
// fit in the remaining capacity, the entire cycle is dropped.
module dpi_chan
  import dpi_pkg::*;
#(
  parameter int  LANS  = 4,
  parameter int  WIDTH = 279620,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANE_DW*LANS-1:0]  dat,
  input  logic [LANE_KW*LANS-1:0]  datk,
  input  logic [LANS-1:0]          datv,
  output logic [CW-1:0]            cnt,
  output logic [31:0]              kcnt,
  output logic [31:0]              sum,
  output logic                     full,
  output logic                     ovf
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   kcnt_q, kcnt_d;
  logic [31:0]   sum_q, sum_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   n;      // valid lanes this cycle
  logic [31:0]   kn;     // K-bits within valid lanes
  logic [31:0]   x;      // XOR of valid lane data
  logic [32:0]   total;  // count if this cycle were captured
  logic          fits;

  always_comb begin
    n  = '0;
    kn = '0;
    x  = '0;
    for (int i = 0; i < LANS; i++) begin
      if (datv[i]) begin
        n  = n + 32'd1;
        kn = kn + popcount(32'(datk[LANE_KW*i +: LANE_KW]));
        x  = x ^ dat[LANE_DW*i +: LANE_DW];
      end
    end
  end

  // Widened so cnt + n cannot wrap before the capacity compare.
  assign total = 33'(cnt_q) + 33'(n);
  assign fits  = (total <= 33'(WIDTH));

  always_comb begin
    cnt_d  = cnt_q;
    kcnt_d = kcnt_q;
    sum_d  = sum_q;
    ovf_d  = ovf_q;
    if (n != 32'd0) begin
      if (fits) begin
        cnt_d  = total[CW-1:0];
        kcnt_d = kcnt_q + kn;
        sum_d  = rotl1(sum_q) ^ x;
      end else begin
        ovf_d = 1'b1;
      end
    end
    // Registered alongside cnt so full always mirrors the registered count.
    full_d = (cnt_d == WIDTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      kcnt_q <= '0;
      sum_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kcnt_q <= kcnt_d;
      sum_q  <= sum_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign kcnt = kcnt_q;
  assign sum  = sum_q;
  assign full = full_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/dpi.sv
// Passive two-direction lane monitor (rx and tx), a debug observer that
// never drives the link. Each direction is an independent dpi_chan.
// Ports:
//   clk, rst_n            : clock; rst_n is a synchronous ACTIVE-HIGH reset
//                           (name kept for system compatibility)
//   rdat/rdatk/rdatv      : rx lane data, K flags, valids
//   tdat/tdatk/tdatv      : tx lane data, K flags, valids
//   rcnt/rkcnt/rsum/rfull/rovf : rx capture statistics
//   tcnt/tkcnt/tsum/tfull/tovf : tx capture statistics
module dpi
  import dpi_pkg::*;
#(
  parameter int  LANS  = 4,
  parameter int  WIDTH = 279620,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANE_DW*LANS-1:0]  rdat,
  input  logic [LANE_KW*LANS-1:0]  rdatk,
  input  logic [LANS-1:0]          rdatv,
  input  logic [LANE_DW*LANS-1:0]  tdat,
  input  logic [LANE_KW*LANS-1:0]  tdatk,
  input  logic [LANS-1:0]          tdatv,
  output logic [CW-1:0]            rcnt,
  output logic [31:0]              rkcnt,
  output logic [31:0]              rsum,
  output logic                     rfull,
  output logic                     rovf,
  output logic [CW-1:0]            tcnt,
  output logic [31:0]              tkcnt,
  output logic [31:0]              tsum,
  output logic                     tfull,
  output logic                     tovf
);

  dpi_chan #(.LANS(LANS), .WIDTH(WIDTH)) u_rx (
    .clk(clk), .rst(rst_n),
    .dat(rdat), .datk(rdatk), .datv(rdatv),
    .cnt(rcnt), .kcnt(rkcnt), .sum(rsum), .full(rfull), .ovf(rovf)
  );

  dpi_chan #(.LANS(LANS), .WIDTH(WIDTH)) u_tx (
    .clk(clk), .rst(rst_n),
    .dat(tdat), .datk(tdatk), .datv(tdatv),
    .cnt(tcnt), .kcnt(tkcnt), .sum(tsum), .full(tfull), .ovf(tovf)
  );

endmodule

// File: tb/tb_dpi.sv
// Bench for dpi: a full-capacity instance and a WIDTH=5 instance share all
// inputs. Constant-expectation vectors and hand sequences cover the named
// corner cases; a queue-free arithmetic model tracks both instances for
// concurrent and random traffic.
module tb_dpi;
  localparam int LANS    = 4;
  localparam int BIG_W   = 279620;
  localparam int SMALL_W = 5;
  localparam int BIG_CW  = $clog2(BIG_W + 1);
  localparam int SM_CW   = $clog2(SMALL_W + 1);

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [127:0] rdat, tdat;
  logic [15:0]  rdatk, tdatk;
  logic [3:0]   rdatv, tdatv;

  logic [BIG_CW-1:0] b_rcnt, b_tcnt;
  logic [31:0] b_rkcnt, b_rsum, b_tkcnt, b_tsum;
  logic b_rfull, b_rovf, b_tfull, b_tovf;
  logic [SM_CW-1:0] s_rcnt, s_tcnt;
  logic [31:0] s_rkcnt, s_rsum, s_tkcnt, s_tsum;
  logic s_rfull, s_rovf, s_tfull, s_tovf;

  dpi u_big (
    .clk(clk), .rst_n(rst_n),
    .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv),
    .tdat(tdat), .tdatk(tdatk), .tdatv(tdatv),
    .rcnt(b_rcnt), .rkcnt(b_rkcnt), .rsum(b_rsum), .rfull(b_rfull), .rovf(b_rovf),
    .tcnt(b_tcnt), .tkcnt(b_tkcnt), .tsum(b_tsum), .tfull(b_tfull), .tovf(b_tovf)
  );

  dpi #(.LANS(LANS), .WIDTH(SMALL_W)) u_small (
    .clk(clk), .rst_n(rst_n),
    .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv),
    .tdat(tdat), .tdatk(tdatk), .tdatv(tdatv),
    .rcnt(s_rcnt), .rkcnt(s_rkcnt), .rsum(s_rsum), .rfull(s_rfull), .rovf(s_rovf),
    .tcnt(s_tcnt), .tkcnt(s_tkcnt), .tsum(s_tsum), .tfull(s_tfull), .tovf(s_tovf)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  // reference model, indexed [instance][direction]
  int          cap [2] = '{BIG_W, SMALL_W};
  int          m_cnt [2][2];
  logic [31:0] m_kc  [2][2];
  logic [31:0] m_sum [2][2];
  logic        m_ovf [2][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] v;
    logic [127:0] d;
    logic [15:0] k;
    logic [31:0] x;
    int n, kn;
    for (int dir = 0; dir < 2; dir++) begin
      v = (dir == 0) ? rdatv : tdatv;
      d = (dir == 0) ? rdat  : tdat;
      k = (dir == 0) ? rdatk : tdatk;
      n = $countones(v);
      x = '0;
      kn = 0;
      for (int l = 0; l < 4; l++) begin
        if (v[l]) begin
          x  = x ^ d[32*l +: 32];
          kn = kn + $countones(k[4*l +: 4]);
        end
      end
      for (int u = 0; u < 2; u++) begin
        if (rst_n) begin
          m_cnt[u][dir] = 0;
          m_kc[u][dir]  = '0;
          m_sum[u][dir] = '0;
          m_ovf[u][dir] = 1'b0;
        end else if (n > 0) begin
          if (m_cnt[u][dir] + n <= cap[u]) begin
            m_cnt[u][dir] = m_cnt[u][dir] + n;
            m_kc[u][dir]  = m_kc[u][dir] + 32'(kn);
            m_sum[u][dir] = ((m_sum[u][dir] << 1) | (m_sum[u][dir] >> 31)) ^ x;
          end else begin
            m_ovf[u][dir] = 1'b1;
          end
        end
      end
    end
  endtask

  // driver: commit current inputs at the next edge, settle, then return
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdat = '0; rdatk = '0; rdatv = '0;
    tdat = '0; tdatk = '0; tdatv = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] act [2][2][5];
    logic [31:0] exp;
    string fld;
    act[0][0] = '{32'(b_rcnt), b_rkcnt, b_rsum, 32'(b_rfull), 32'(b_rovf)};
    act[0][1] = '{32'(b_tcnt), b_tkcnt, b_tsum, 32'(b_tfull), 32'(b_tovf)};
    act[1][0] = '{32'(s_rcnt), s_rkcnt, s_rsum, 32'(s_rfull), 32'(s_rovf)};
    act[1][1] = '{32'(s_tcnt), s_tkcnt, s_tsum, 32'(s_tfull), 32'(s_tovf)};
    for (int u = 0; u < 2; u++) begin
      for (int dir = 0; dir < 2; dir++) begin
        for (int f = 0; f < 5; f++) begin
          case (f)
            0: begin exp = 32'(m_cnt[u][dir]); fld = "cnt"; end
            1: begin exp = m_kc[u][dir]; fld = "kcnt"; end
            2: begin exp = m_sum[u][dir]; fld = "sum"; end
            3: begin exp = 32'(m_cnt[u][dir] == cap[u]); fld = "full"; end
            default: begin exp = 32'(m_ovf[u][dir]); fld = "ovf"; end
          endcase
          chk($sformatf("%s %s.%s%s", tag, (u == 0) ? "big" : "small",
                        (dir == 0) ? "r" : "t", fld), act[u][dir][f], exp);
        end
      end
    end
  endtask

  typedef struct {
    logic [3:0]   rv;
    logic [127:0] rd;
    logic [15:0]  rk;
    logic [3:0]   tv;
    logic [127:0] td;
    logic [15:0]  tk;
    logic [31:0]  e_rcnt, e_rkcnt, e_rsum, e_tcnt, e_tkcnt, e_tsum;
  } vec_t;

  vec_t vecs [5];

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // single-cycle-from-reset vectors with constant expectations
    vecs[0] = '{4'h1, {96'h0, 32'h11111111}, 16'h1111, 4'h0, 128'h0, 16'h0,
                32'd1, 32'd1, 32'h11111111, 32'd0, 32'd0, 32'h0};
    vecs[1] = '{4'h0, 128'h0, 16'h0, 4'hF, {4{32'h22222222}}, 16'h2222,
                32'd0, 32'd0, 32'h0, 32'd4, 32'd4, 32'h0};
    vecs[2] = '{4'b0101, {32'hFFFFFFFF, 32'h0F0F0F0F, 32'hDEADBEEF, 32'h12345678}, 16'hFFF0,
                4'b1000, {32'h80000000, 96'h0}, 16'h8000,
                32'd2, 32'd4, 32'h1D3B5977, 32'd1, 32'd1, 32'h80000000};
    vecs[3] = '{4'h0, {4{32'hA5A5A5A5}}, 16'hFFFF, 4'h0, {4{32'h5A5A5A5A}}, 16'hFFFF,
                32'd0, 32'd0, 32'h0, 32'd0, 32'd0, 32'h0};
    vecs[4] = '{4'b1110, {32'h4, 32'h2, 32'h1, 32'hCAFEF00D}, 16'h000F, 4'h0, 128'h0, 16'h0,
                32'd3, 32'd0, 32'h7, 32'd0, 32'd0, 32'h0};

    // reset held two cycles with valid traffic, then released idle
    rdatv = 4'hF; tdatv = 4'hF; rdat = {4{32'hFFFFFFFF}}; rdatk = 16'hFFFF;
    rst_n = 1'b1;
    step();
    step();
    check_all("reset");
    rst_n = 1'b0;
    clear_inputs();
    step();
    check_all("post_reset_idle");

    for (int i = 0; i < 5; i++) begin
      do_reset();
      rdatv = vecs[i].rv; rdat = vecs[i].rd; rdatk = vecs[i].rk;
      tdatv = vecs[i].tv; tdat = vecs[i].td; tdatk = vecs[i].tk;
      step();
      chk($sformatf("vec%0d rcnt", i), 32'(b_rcnt), vecs[i].e_rcnt);
      chk($sformatf("vec%0d rkcnt", i), b_rkcnt, vecs[i].e_rkcnt);
      chk($sformatf("vec%0d rsum", i), b_rsum, vecs[i].e_rsum);
      chk($sformatf("vec%0d tcnt", i), 32'(b_tcnt), vecs[i].e_tcnt);
      chk($sformatf("vec%0d tkcnt", i), b_tkcnt, vecs[i].e_tkcnt);
      chk($sformatf("vec%0d tsum", i), b_tsum, vecs[i].e_tsum);
      check_all($sformatf("vec%0d", i));
    end

    // all lanes then a single lane on tx
    do_reset();
    tdatv = 4'hF; tdat = {4{32'h22222222}}; tdatk = 16'h2222;
    step();
    tdatv = 4'h1; tdat = {96'h0, 32'h00000001}; tdatk = 16'h0;
    step();
    chk("tx_seq tcnt", 32'(b_tcnt), 32'd5);
    chk("tx_seq tsum", b_tsum, 32'h1);
    chk("tx_seq tkcnt", b_tkcnt, 32'd4);

    // checksum rotates left before folding in new data
    do_reset();
    rdatv = 4'h1; rdat = {96'h0, 32'h80000001};
    step();
    rdat = '0;
    step();
    chk("rot rsum", b_rsum, 32'h00000003);
    chk("rot rcnt", 32'(b_rcnt), 32'd2);

    // overflow on the WIDTH=5 instance
    do_reset();
    rdatv = 4'hF; rdat = {4{32'h0000000F}};
    step();
    chk("ovf1 s_rcnt", 32'(s_rcnt), 32'd4);
    chk("ovf1 s_rovf", 32'(s_rovf), 32'd0);
    step();
    chk("ovf2 s_rcnt", 32'(s_rcnt), 32'd4);
    chk("ovf2 s_rovf", 32'(s_rovf), 32'd1);
    chk("ovf2 s_rsum", s_rsum, 32'h0);
    rdatv = 4'h1;
    step();
    chk("ovf3 s_rcnt", 32'(s_rcnt), 32'd5);
    chk("ovf3 s_rfull", 32'(s_rfull), 32'd1);
    chk("ovf3 s_rovf", 32'(s_rovf), 32'd1);
    step();
    check_all("ovf4");

    // reset mid-operation dominates simultaneous valid input
    do_reset();
    rdatv = 4'h7; rdat = {4{32'h13579BDF}};
    step();
    chk("mid rcnt", 32'(b_rcnt), 32'd3);
    rst_n = 1'b1; rdatv = 4'hF; tdatv = 4'hF;
    step();
    check_all("mid_reset");
    rst_n = 1'b0;
    clear_inputs();

    // concurrent incrementing traffic with tx idles in between
    for (int i = 1; i <= 10; i++) begin
      rdatv = 4'(i);
      tdatv = (i % 3 == 0) ? 4'h0 : 4'(11 - i);
      rdat = {$urandom, $urandom, $urandom, $urandom};
      tdat = {$urandom, $urandom, $urandom, $urandom};
      rdatk = 16'($urandom); tdatk = 16'($urandom);
      step();
      check_all($sformatf("conc%0d", i));
    end
    rdatv = 4'h0; tdatv = 4'h0; rdat = '1;
    step();
    check_all("idle");

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 59) == 0);
      rdatv = 4'($urandom_range(0, 15));
      tdatv = 4'($urandom_range(0, 15));
      rdat = {$urandom, $urandom, $urandom, $urandom};
      tdat = {$urandom, $urandom, $urandom, $urandom};
      rdatk = 16'($urandom); tdatk = 16'($urandom);
      step();
      check_all($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
